// File: rtl/vga_cell_renderer_pkg.sv
// Shared constants for the VGA cell renderer and for processor-side drivers
// that compute cell indices or write colours into the grid.
package vga_cell_renderer_pkg;

    localparam int H_VISIBLE  = 640;
    localparam int V_VISIBLE  = 480;
    localparam int CELL_SHIFT = 3;
    localparam int COLS       = H_VISIBLE >> CELL_SHIFT;
    localparam int ROWS       = V_VISIBLE >> CELL_SHIFT;
    localparam int CELL_COUNT = COLS * ROWS;
    localparam int CELL_AW    = 13;

    localparam logic [7:0] RGB_BLACK = 8'h00;

    // One processor write request as seen on the write port.
    typedef struct packed {
        logic [CELL_AW-1:0] addr;
        logic [7:0]         data;
    } cell_wr_t;

    // Cell index row*80+col built from shifts only.
    function automatic logic [CELL_AW-1:0] cell_index(input logic [9:0] px, input logic [9:0] py);
        logic [CELL_AW-1:0] row;
        logic [CELL_AW-1:0] col;
        row = CELL_AW'(py >> CELL_SHIFT);
        col = CELL_AW'(px >> CELL_SHIFT);
        return (row << 6) + (row << 4) + col;
    endfunction

endpackage

// File: rtl/vga_cell_renderer_cell_wr_fifo.sv
// Small synchronous FIFO buffering processor cell writes until the video
// path leaves the RAM port idle.
module cell_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full_o     = (count_q == (PW+1)'(DEPTH));
        empty_o    = (count_q == '0);
        do_push    = push_i && !full_o;
        do_pop     = pop_i && !empty_o;
        pop_data_o = mem_q[rptr_q];
        wptr_d     = do_push ? wptr_q + PW'(1) : wptr_q;
        rptr_d     = do_pop  ? rptr_q + PW'(1) : rptr_q;
        count_d    = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/vga_cell_renderer.sv
// Pixel stage after the sync generator: maps raster position to an 8x8 colour
// cell in an internal RAM and emits RRRGGGBB with syncs delayed to match.
module vga_cell_renderer #(
    parameter int COLS       = 80,
    parameter int ROWS       = 60,
    parameter int ADDR_W     = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              activeVideo,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic [7:0]        rgb,
    output logic              hsync,
    output logic              vsync,
    output logic              wr_pending
);

    import vga_cell_renderer_pkg::*;

    localparam int CELLS = COLS * ROWS;
    localparam int FW    = ADDR_W + 8;

    logic              vis_d;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] row_sel, col_sel;

    logic              vis_s0_q, hs_s0_q, vs_s0_q;
    logic [ADDR_W-1:0] addr_s0_q;
    logic              vis_s1_q, hs_s1_q, vs_s1_q;
    logic [7:0]        ram_q;
    logic [7:0]        rgb_q, rgb_d;
    logic              hsync_q, vsync_q;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FW-1:0]     fifo_rd_data;
    logic [ADDR_W-1:0] pop_addr;
    logic [7:0]        pop_data;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        mem [0:CELLS-1];

    // The position range check guards against a sync generator that asserts
    // activeVideo outside 640x480.
    always_comb begin
        vis_d   = activeVideo && (x < 10'(H_VISIBLE)) && (y < 10'(V_VISIBLE));
        row_sel = ADDR_W'(y >> CELL_SHIFT);
        col_sel = ADDR_W'(x >> CELL_SHIFT);
        addr_d  = (row_sel << 6) + (row_sel << 4) + col_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vis_s0_q <= 1'b0;
            hs_s0_q  <= 1'b1;
            vs_s0_q  <= 1'b1;
            vis_s1_q <= 1'b0;
            hs_s1_q  <= 1'b1;
            vs_s1_q  <= 1'b1;
            rgb_q    <= RGB_BLACK;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
        end else begin
            vis_s0_q <= vis_d;
            hs_s0_q  <= hsync_in;
            vs_s0_q  <= vsync_in;
            vis_s1_q <= vis_s0_q;
            hs_s1_q  <= hs_s0_q;
            vs_s1_q  <= vs_s0_q;
            rgb_q    <= rgb_d;
            hsync_q  <= hs_s1_q;
            vsync_q  <= vs_s1_q;
        end
    end

    always_ff @(posedge clk) begin
        addr_s0_q <= addr_d;
    end

    cell_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_wr_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i ({wr_addr, wr_data}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rd_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Video owns the single RAM port whenever stage 0 is visible; buffered
    // writes only drain in the gaps. Out-of-range entries pop without a write.
    always_comb begin
        wr_ready   = !fifo_full && !rst;
        wr_pending = !fifo_empty;
        fifo_push  = wr_valid && wr_ready;
        pop_addr   = fifo_rd_data[FW-1:8];
        pop_data   = fifo_rd_data[7:0];
        fifo_pop   = !vis_s0_q && !fifo_empty && !rst;
        ram_we     = fifo_pop && (pop_addr < ADDR_W'(CELLS));
        ram_addr   = vis_s0_q ? addr_s0_q : pop_addr;
        rgb_d      = vis_s1_q ? ram_q : RGB_BLACK;
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= pop_data;
        end
        ram_q <= mem[ram_addr];
    end

    assign rgb   = rgb_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;

endmodule

// File: tb/tb_vga_cell_renderer.sv
// Directed bench for vga_cell_renderer: a scoreboard queue holds the expected
// colour/sync for every driven pixel and is checked 3 clocks later.
module tb_vga_cell_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x, y;
    logic        activeVideo, hsync_in, vsync_in;
    logic        wr_valid, wr_ready, wr_pending;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  rgb;
    logic        hsync, vsync;

    always #5 clk = ~clk;

    vga_cell_renderer #(
        .COLS (80), .ROWS (60), .ADDR_W (13), .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .y           (y),
        .activeVideo (activeVideo),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rgb         (rgb),
        .hsync       (hsync),
        .vsync       (vsync),
        .wr_pending  (wr_pending)
    );

    typedef struct {
        int         due;
        bit         rgb_chk;
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t       sb[$];
    int         cycle = 0;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] model [0:4799];
    bit         known [0:4799];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cycle);
        end
    endtask

    // Push the expectation for the inputs currently driven, advance one clock,
    // then compare every scoreboard entry that falls due on this clock.
    task automatic tick();
        exp_t e;
        int   a;
        if (!rst) begin
            e.due = cycle + 3;
            e.hs  = hsync_in;
            e.vs  = vsync_in;
            if (activeVideo && x < 640 && y < 480) begin
                a         = (int'(y) / 8) * 80 + int'(x) / 8;
                e.rgb_chk = known[a];
                e.rgb     = model[a];
            end else begin
                e.rgb_chk = 1'b1;
                e.rgb     = 8'h00;
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cycle++;
        while (sb.size() > 0 && sb[0].due == cycle) begin
            e = sb.pop_front();
            if (e.rgb_chk) chk("rgb", {8'h00, rgb}, {8'h00, e.rgb});
            chk("hsync", {15'h0, hsync}, {15'h0, e.hs});
            chk("vsync", {15'h0, vsync}, {15'h0, e.vs});
        end
    endtask

    task automatic pix(input int xv, input int yv, input bit av);
        x           = 10'(xv);
        y           = 10'(yv);
        activeVideo = av;
        hsync_in    = !(xv >= 656 && xv < 752);
        vsync_in    = !(yv >= 490 && yv < 492);
    endtask

    task automatic scan(input int yv, input int x0, input int x1, input bit force_av);
        for (int xv = x0; xv <= x1; xv++) begin
            pix(xv, yv, force_av ? 1'b1 : (xv < 640 && yv < 480));
            tick();
        end
    endtask

    // Single write during blanking; waits a bounded time for wr_ready.
    task automatic wr(input int a, input logic [7:0] d);
        int n;
        wr_valid = 1'b1;
        wr_addr  = 13'(a);
        wr_data  = d;
        n = 0;
        while (!wr_ready && n < 20) begin
            tick();
            n++;
        end
        chk("wr_ready_wait", {15'h0, wr_ready}, 16'h1);
        tick();
        wr_valid = 1'b0;
        if (a < 4800) begin
            model[a] = d;
            known[a] = 1'b1;
        end
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        pix(0, 0, 1'b1);

        // Reset held 5 clocks with sync inputs toggling
        for (int i = 0; i < 5; i++) begin
            hsync_in = i[0];
            vsync_in = ~i[0];
            tick();
            chk("rst_rgb",     {8'h00, rgb},       16'h0);
            chk("rst_hsync",   {15'h0, hsync},     16'h1);
            chk("rst_vsync",   {15'h0, vsync},     16'h1);
            chk("rst_ready",   {15'h0, wr_ready},  16'h0);
            chk("rst_pending", {15'h0, wr_pending}, 16'h0);
        end
        rst = 1'b0;
        pix(700, 500, 1'b0);
        tick();
        chk("ready_after_rst", {15'h0, wr_ready}, 16'h1);

        // Alignment: two cells written in vertical blank, then 16 rows scanned
        pix(0, 490, 1'b0);
        wr(0, 8'hE0);
        wr(81, 8'h1C);
        repeat (4) tick();
        pix(0, 495, 1'b0);
        repeat (4) tick();
        for (int r = 0; r < 16; r++) scan(r, 0, 799, 1'b0);

        // Blanking: preload whole grid with FF
        pix(700, 500, 1'b0);
        for (int a = 0; a < 4800; a++) wr(a, 8'hFF);
        repeat (4) tick();
        scan(0, 0, 799, 1'b0);
        scan(1, 0, 799, 1'b1);
        scan(479, 0, 799, 1'b0);
        scan(480, 0, 15, 1'b1);

        // Arbitration: 4 writes at the start of a visible run
        pix(799, 1, 1'b0);
        tick();
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pix(i, 2, 1'b1);
            wr_addr = (i == 1) ? 13'd4721 : (i == 3) ? 13'd4722 : 13'd4720;
            wr_data = (i == 0) ? 8'h11 : (i == 1) ? 8'h22 : (i == 2) ? 8'h33 : 8'h44;
            chk("arb_ready_pre", {15'h0, wr_ready}, 16'h1);
            tick();
        end
        wr_valid = 1'b0;
        chk("arb_ready_full", {15'h0, wr_ready}, 16'h0);
        for (int xv = 4; xv <= 644; xv++) begin
            pix(xv, 2, xv < 640);
            tick();
            if (xv <= 640) begin
                chk("arb_hold_ready",   {15'h0, wr_ready},   16'h0);
                chk("arb_hold_pending", {15'h0, wr_pending}, 16'h1);
            end else begin
                chk("arb_drain_ready",   {15'h0, wr_ready},   16'h1);
                chk("arb_drain_pending", {15'h0, wr_pending}, (xv == 644) ? 16'h0 : 16'h1);
            end
        end
        model[4720] = 8'h33;
        model[4721] = 8'h22;
        model[4722] = 8'h44;
        scan(2, 645, 799, 1'b0);
        scan(472, 0, 31, 1'b0);

        // Out-of-range entry, then push/pop in the same cycle at occupancy 2
        pix(799, 7, 1'b0);
        tick();
        pix(0, 8, 1'b1); wr_valid = 1'b1; wr_addr = 13'd4800; wr_data = 8'h77;
        tick();
        pix(1, 8, 1'b1); wr_addr = 13'd5; wr_data = 8'h03;
        tick();
        pix(2, 8, 1'b0); wr_valid = 1'b0;
        tick();
        pix(3, 8, 1'b1); wr_valid = 1'b1; wr_addr = 13'd10; wr_data = 8'h0A;
        chk("pp_ready_occ2", {15'h0, wr_ready}, 16'h1);
        tick();
        pix(4, 8, 1'b1); wr_addr = 13'd11; wr_data = 8'h0B;
        chk("pp_ready_occ2b", {15'h0, wr_ready}, 16'h1);
        tick();
        pix(5, 8, 1'b1); wr_addr = 13'd12; wr_data = 8'h0C;
        chk("pp_ready_occ3", {15'h0, wr_ready}, 16'h1);
        tick();
        wr_valid = 1'b0;
        chk("pp_full", {15'h0, wr_ready}, 16'h0);
        scan(8, 6, 799, 1'b0);
        chk("pp_drained", {15'h0, wr_pending}, 16'h0);
        model[5]  = 8'h03;
        model[10] = 8'h0A;
        model[11] = 8'h0B;
        model[12] = 8'h0C;
        scan(0, 0, 103, 1'b0);
        scan(64, 512, 519, 1'b0);

        // Reset with 3 writes buffered during a visible run
        pix(799, 7, 1'b0);
        tick();
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pix(i, 8, 1'b1);
            wr_addr = 13'(20 + i);
            wr_data = 8'h55;
            tick();
        end
        wr_valid = 1'b0;
        pix(3, 8, 1'b1);
        chk("mid_pending_pre", {15'h0, wr_pending}, 16'h1);
        rst = 1'b1;
        sb.delete();
        tick();
        chk("mid_pending", {15'h0, wr_pending}, 16'h0);
        chk("mid_ready",   {15'h0, wr_ready},   16'h0);
        chk("mid_rgb",     {8'h00, rgb},        16'h0);
        chk("mid_hsync",   {15'h0, hsync},      16'h1);
        chk("mid_vsync",   {15'h0, vsync},      16'h1);
        rst = 1'b0;
        pix(700, 500, 1'b0);
        repeat (6) tick();
        chk("mid_pending_post", {15'h0, wr_pending}, 16'h0);
        scan(0, 152, 183, 1'b0);
        pix(700, 500, 1'b0);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
